// File: rtl/mul32_if.sv
// ---------------------------------------------------------------------------
// mul32_if
// Request/response bundle between the execute-stage controller and the
// sequential 32x32 multiplier.
//   start  : request a multiply (honoured only when the multiplier is idle)
//   sgn    : 1 = signed (MULT), 0 = unsigned (MULTU), sampled with start
//   a, b   : 32-bit operands, sampled with start
//   busy   : operation in progress (controller stalls on it)
//   done   : one-cycle pulse when hi/lo carry a new product
//   hi, lo : upper / lower 32 bits of the 64-bit product
// Modports: master = requester (controller / bench), slave = multiplier.
// ---------------------------------------------------------------------------
interface mul32_if;
   logic        start;
   logic        sgn;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, sgn, a, b, input  busy, done, hi, lo);
   modport slave  (input  start, sgn, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul32_seq.sv
// ---------------------------------------------------------------------------
// mul32_seq
// Multi-cycle 32x32 integer multiplier (MULT / MULTU) producing a 64-bit
// HI/LO result with a radix-2 shift-add datapath. Signed operands are
// reduced to magnitudes up front and the product is negated at the end,
// so the core loop is purely unsigned. All partial-product accumulation
// goes through the single carry-lookahead adder instance u_cla.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mul32_if.slave (start, sgn, a, b in; busy, done, hi, lo out)
//
// Parameter:
//   ITER   : shift-add iterations, equal to the operand width (32)
//
// Optional build macro:
//   MUL_ZERO_SKIP_EN : when defined, a request with a zero operand completes
//                      immediately (done in the cycle after the start edge,
//                      busy never raised, hi=lo=0). Undefined (default):
//                      every request takes the full 34-cycle path.
//
// Timing: start sampled at edge N -> 32 CALC cycles, 1 SIGN cycle, 1 DONE
// cycle -> done high in the cycle following edge N+34; busy high 33 cycles.
// ---------------------------------------------------------------------------
module mul32_seq #(
   parameter int ITER = 32
) (
   input  logic    clk,
   input  logic    rst_n,
   mul32_if.slave  bus
);
   localparam int CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               neg;
   logic [31:0]        mcand;
   logic [31:0]        p_hi;
   logic [31:0]        p_lo;
   logic [31:0]        add_s;
   logic               add_c;
   logic [32:0]        acc;
   logic [31:0]        a_mag;
   logic [31:0]        b_mag;
   logic               zero_op;

   // Absolute value for signed requests; 0x80000000 maps to 2^31, which is
   // still exact as an unsigned 32-bit magnitude.
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

   mul32_cla32 u_cla (
      .a    (p_hi),
      .b    (mcand),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_c)
   );

   always_comb begin
      a_mag = magnitude(bus.a, bus.sgn);
      b_mag = magnitude(bus.b, bus.sgn);
      // Add the multiplicand only when the current multiplier bit is set.
      acc   = p_lo[0] ? {add_c, add_s} : {1'b0, p_hi};
   end

`ifdef MUL_ZERO_SKIP_EN
   assign zero_op = (bus.a == 32'd0) || (bus.b == 32'd0);
`else
   assign zero_op = 1'b0;
`endif

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         neg      <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.hi   <= 32'd0;
         bus.lo   <= 32'd0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  if (zero_op) begin
                     // Short-circuit: the result is known to be zero, so the
                     // completion pulse is issued straight from IDLE.
                     bus.done <= 1'b1;
                     bus.hi   <= 32'd0;
                     bus.lo   <= 32'd0;
                  end else begin
                     state    <= CALC;
                     bus.busy <= 1'b1;
                     cnt      <= '0;
                     neg      <= bus.sgn & (bus.a[31] ^ bus.b[31]);
                  end
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER - 1)) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               state    <= DONE;
               bus.busy <= 1'b0;
            end
            DONE: begin
               bus.hi   <= p_hi;
               bus.lo   <= p_lo;
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Product datapath; only the FSM state gates it, so it needs no reset.
   always_ff @(posedge clk) begin
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               mcand <= a_mag;
               p_hi  <= 32'd0;
               p_lo  <= b_mag;
            end
         end
         CALC: begin
            // 65-bit {carry, sum, p_lo} shifted right by one into 64 bits.
            p_hi <= acc[32:1];
            p_lo <= {acc[0], p_lo[31:1]};
         end
         SIGN: begin
            if (neg) begin
               {p_hi, p_lo} <= ~{p_hi, p_lo} + 64'd1;
            end
         end
         default: ;
      endcase
   end
endmodule

// ---------------------------------------------------------------------------
// mul32_cla32
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups, with the
// group carry passed from one group to the next.
//   a, b : addends       cin  : carry in
//   s    : sum           cout : carry out
// ---------------------------------------------------------------------------
module mul32_cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);
   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;

   always_comb begin
      logic       carry;
      logic [3:0] gg;
      logic [3:0] pp;
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      carry = cin;
      for (int k = 0; k < 8; k++) begin
         gg         = g[4*k +: 4];
         pp         = p[4*k +: 4];
         c[4*k]     = carry;
         c[4*k + 1] = gg[0] | (pp[0] & carry);
         c[4*k + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
         c[4*k + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & carry);
         carry      = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & carry);
      end
      s    = p ^ c;
      cout = carry;
   end
endmodule

// File: tb/tb_mul32_seq.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq
// Self-checking bench for mul32_seq: directed vectors for the documented
// corner cases plus randomized signed/unsigned operations, checked against
// a plain 64-bit arithmetic reference. Honours MUL_ZERO_SKIP_EN if defined.
// ---------------------------------------------------------------------------
module tb_mul32_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   mul32_if bus ();

   mul32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference product: sign- or zero-extend to 64 bits and multiply; the
   // mod-2^64 result is the exact product for both signed and unsigned.
   function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] ex;
      logic [63:0] ey;
      ex = s ? {{32{x[31]}}, x} : {32'h0, x};
      ey = s ? {{32{y[31]}}, y} : {32'h0, y};
      return ex * ey;
   endfunction

   function automatic int expected_latency(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_ZERO_SKIP_EN
      return (x == 32'd0 || y == 32'd0) ? 0 : 34;
`else
      return (x == y && x == 32'hDEAD_BEEF) ? 34 : 34;
`endif
   endfunction

   // Present a request for one edge, then scramble operands so any
   // re-sampling after the start edge would corrupt the result.
   task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sgn   = s;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.sgn   = 1'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   // Starting 1 time unit after an edge, count edges until done is seen.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!bus.done && lat < 120) begin
         if (bus.busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp_prod);
      int lat;
      int bcnt;
      int exp_lat;
      exp_lat = expected_latency(x, y);
      launch(s, x, y);
      wait_done(lat, bcnt);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_cycles"}, 64'(bcnt), 64'((exp_lat == 34) ? 33 : 0));
      check({tag, " product"}, {bus.hi, bus.lo}, exp_prod);
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, 64'(bus.done), 64'(0));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] prev;
      logic [31:0] x;
      logic [31:0] y;
      logic        s;
      int          lat;
      int          bcnt;
      int          ndone;

      bus.start = 1'b0;
      bus.sgn   = 1'b0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      check("reset hilo", {bus.hi, bus.lo}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("u_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      run_op("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("s_minx1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

      // start during CALC is ignored; operands from the first request win
      prev = {bus.hi, bus.lo};
      launch(1'b0, 32'd7, 32'd6);
      repeat (9) @(posedge clk);
      launch(1'b0, 32'd2, 32'd2);
      check("ign hilo_hold", {bus.hi, bus.lo}, prev);
      wait_done(lat, bcnt);
      check("ign latency", 64'(lat + 10), 64'(34));
      check("ign product", {bus.hi, bus.lo}, 64'd42);
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check("ign no_second_done", 64'(ndone), 64'(0));
      run_op("ign_followup", 1'b0, 32'd2, 32'd2, 64'd4);

      // reset in the middle of an operation
      launch(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst busy", 64'(bus.busy), 64'(0));
      check("midrst done", 64'(bus.done), 64'(0));
      check("midrst hilo", {bus.hi, bus.lo}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("midrst_fresh", 1'b0, 32'd3, 32'd4, 64'd12);

      run_op("zero_op", 1'b1, 32'd0, 32'h55, 64'h0);

      // start held high: next request accepted on the first IDLE cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.sgn   = 1'b0;
      bus.a     = 32'd9;
      bus.b     = 32'd11;
      @(posedge clk);
      #1;
      wait_done(lat, bcnt);
      check("held first_latency", 64'(lat), 64'(34));
      check("held first_product", {bus.hi, bus.lo}, 64'd99);
      @(posedge clk);
      #1;
      wait_done(lat, bcnt);
      bus.start = 1'b0;
      check("held done_gap", 64'(lat + 1), 64'(35));
      check("held second_product", {bus.hi, bus.lo}, 64'd99);
      repeat (3) @(posedge clk);

      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: x = 32'h8000_0000;
            1: y = 32'hFFFF_FFFF;
            2: begin x = 32'h7FFF_FFFF; y = 32'h8000_0000; end
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), s, x, y, ref_mul(s, x, y));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
